// File: rtl/pipe_comparator.sv
`default_nettype none
// ============================================================================
// Module   : pipe_comparator
// Brief    : Two-stage valid/ready magnitude comparator with per-pair
//            signed/unsigned mode and saturating per-outcome event counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_comparator #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             AeqB,
   output logic             AgtB,
   output logic             AltB,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] lt_cnt
);

   localparam logic [CNT_W-1:0] c_cntMax = '1;

   logic             r_s1Valid;
   logic             r_s1Signed;
   logic [WIDTH-1:0] r_s1A;
   logic [WIDTH-1:0] r_s1B;
   logic             r_s2Valid;
   logic             r_eq;
   logic             r_gt;
   logic             r_lt;
   logic             w_s1Adv;
   logic             w_s2Adv;
   logic             w_outHs;
   logic [WIDTH-1:0] w_keyA;
   logic [WIDTH-1:0] w_keyB;
   logic [2:0]       w_hit;

   // A stage may load when empty or when its content leaves this cycle.
   assign w_s2Adv  = !r_s2Valid | out_ready;
   assign w_s1Adv  = !r_s1Valid | w_s2Adv;
   assign in_ready = w_s1Adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid  <= 1'b0;
         r_s1Signed <= 1'b0;
         r_s1A      <= '0;
         r_s1B      <= '0;
      end else if (w_s1Adv) begin
         r_s1Valid <= in_valid;
         if (in_valid) begin
            r_s1A      <= A;
            r_s1B      <= B;
            r_s1Signed <= signed_mode;
         end
      end
   end

   // Flipping the sign bits maps two's-complement order onto unsigned order.
   assign w_keyA = {r_s1A[WIDTH-1] ^ r_s1Signed, r_s1A[WIDTH-2:0]};
   assign w_keyB = {r_s1B[WIDTH-1] ^ r_s1Signed, r_s1B[WIDTH-2:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2Valid <= 1'b0;
         r_eq      <= 1'b0;
         r_gt      <= 1'b0;
         r_lt      <= 1'b0;
      end else if (w_s2Adv) begin
         r_s2Valid <= r_s1Valid;
         r_eq      <= r_s1Valid & (w_keyA == w_keyB);
         r_gt      <= r_s1Valid & (w_keyA >  w_keyB);
         r_lt      <= r_s1Valid & (w_keyA <  w_keyB);
      end
   end

   assign out_valid = r_s2Valid;
   assign AeqB      = r_eq;
   assign AgtB      = r_gt;
   assign AltB      = r_lt;

   assign w_outHs = r_s2Valid & out_ready;
   assign w_hit   = {r_lt, r_gt, r_eq} & {3{w_outHs}};

   // Index 0 = eq, 1 = gt, 2 = lt; clear has priority over a same-cycle hit.
   for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else if (clr_cnt) begin
            r_cnt <= '0;
         end else if (w_hit[gi] && (r_cnt != c_cntMax)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign eq_cnt = g_cnt[0].r_cnt;
   assign gt_cnt = g_cnt[1].r_cnt;
   assign lt_cnt = g_cnt[2].r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_comparator
// Brief    : Self-checking bench; three comparator instances (8/2, 4/16, 12/16)
//            share one stimulus stream and are checked against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_comparator;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        inValid = 1'b0;
   logic        outReady = 1'b0;
   logic        sm = 1'b0;
   logic        clrCnt = 1'b0;
   logic [11:0] a = '0;
   logic [11:0] b = '0;

   logic        inRdy [3];
   logic        outVld [3];
   logic        eqF [3];
   logic        gtF [3];
   logic        ltF [3];
   logic [1:0]  c8 [3];
   logic [15:0] c4 [3];
   logic [15:0] c12 [3];

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic        sm;
      int          cyc;
   } item_t;

   item_t q[$];
   int    cyc = 0;
   int    nChecks = 0;
   int    nFails = 0;
   int    expCnt [3][3];
   int    widthOf [3] = '{8, 4, 12};
   int    cntMax [3] = '{3, 65535, 65535};

   always #5 clk = ~clk;

   pipe_comparator #(.WIDTH(8), .CNT_W(2)) u8 (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inRdy[0]),
      .A(a[7:0]), .B(b[7:0]), .signed_mode(sm), .out_valid(outVld[0]),
      .out_ready(outReady), .AeqB(eqF[0]), .AgtB(gtF[0]), .AltB(ltF[0]),
      .clr_cnt(clrCnt), .eq_cnt(c8[0]), .gt_cnt(c8[1]), .lt_cnt(c8[2]));

   pipe_comparator #(.WIDTH(4), .CNT_W(16)) u4 (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inRdy[1]),
      .A(a[3:0]), .B(b[3:0]), .signed_mode(sm), .out_valid(outVld[1]),
      .out_ready(outReady), .AeqB(eqF[1]), .AgtB(gtF[1]), .AltB(ltF[1]),
      .clr_cnt(clrCnt), .eq_cnt(c4[0]), .gt_cnt(c4[1]), .lt_cnt(c4[2]));

   pipe_comparator #(.WIDTH(12), .CNT_W(16)) u12 (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inRdy[2]),
      .A(a), .B(b), .signed_mode(sm), .out_valid(outVld[2]),
      .out_ready(outReady), .AeqB(eqF[2]), .AgtB(gtF[2]), .AltB(ltF[2]),
      .clr_cnt(clrCnt), .eq_cnt(c12[0]), .gt_cnt(c12[1]), .lt_cnt(c12[2]));

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Reference compare on integer values: {lt, gt, eq}.
   function automatic logic [2:0] refFlags(logic [11:0] x, logic [11:0] y, logic s, int w);
      int va, vb;
      va = int'(x) % (1 << w);
      vb = int'(y) % (1 << w);
      if (s) begin
         if (va >= (1 << (w - 1))) va -= (1 << w);
         if (vb >= (1 << (w - 1))) vb -= (1 << w);
      end
      if (va == vb) return 3'b001;
      if (va > vb)  return 3'b010;
      return 3'b100;
   endfunction

   function automatic int actCnt(int d, int k);
      case (d)
         0:       return int'(c8[k]);
         1:       return int'(c4[k]);
         default: return int'(c12[k]);
      endcase
   endfunction

   // Called at a falling edge with inputs already driven; returns at the next one.
   task automatic tick();
      bit expOv, expIr, inHs, outHs;
      logic [2:0] f;
      item_t it;
      #1;
      expOv = (q.size() > 0) && (cyc - q[0].cyc >= 2);
      expIr = (q.size() < 2) || outReady;
      inHs  = inValid && expIr;
      outHs = expOv && outReady;
      for (int d = 0; d < 3; d++) begin
         f = expOv ? refFlags(q[0].a, q[0].b, q[0].sm, widthOf[d]) : 3'b000;
         checkEq($sformatf("outValid[w%0d]", widthOf[d]), 32'(outVld[d]), 32'(expOv));
         checkEq($sformatf("inReady[w%0d]", widthOf[d]), 32'(inRdy[d]), 32'(expIr));
         checkEq($sformatf("flags[w%0d]", widthOf[d]), 32'({ltF[d], gtF[d], eqF[d]}), 32'(f));
         for (int k = 0; k < 3; k++) begin
            checkEq($sformatf("cnt%0d[w%0d]", k, widthOf[d]), 32'(actCnt(d, k)), 32'(expCnt[d][k]));
            if (clrCnt) expCnt[d][k] = 0;
            else if (outHs && f[k] && expCnt[d][k] < cntMax[d]) expCnt[d][k]++;
         end
      end
      if (outHs) void'(q.pop_front());
      if (inHs) begin
         it.a = a; it.b = b; it.sm = sm; it.cyc = cyc;
         q.push_back(it);
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic sendPair(input logic [11:0] x, input logic [11:0] y, input logic s);
      inValid = 1'b1; a = x; b = y; sm = s;
      tick();
      inValid = 1'b0;
   endtask

   task automatic idle(input int n);
      inValid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clearModel();
      q.delete();
      foreach (expCnt[d, k]) expCnt[d][k] = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clearModel();
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      outReady = 1'b1;
      idle(2);

      // Reset with two pairs in flight
      outReady = 1'b0;
      sendPair(12'h011, 12'h022, 1'b0);
      sendPair(12'h033, 12'h033, 1'b0);
      rstN = 1'b0;
      #1;
      checkEq("asyncRstOutValid", 32'(outVld[0]), 32'd0);
      @(negedge clk);
      clearModel();
      rstN = 1'b1;
      outReady = 1'b1;
      idle(4);

      // Directed compares
      sendPair(12'h080, 12'h07F, 1'b0);
      sendPair(12'h080, 12'h07F, 1'b1);
      sendPair(12'h0A5, 12'h0A5, 1'b0);
      sendPair(12'h0FF, 12'h001, 1'b1);
      idle(3);
      checkEq("t2eqCnt", 32'(c8[0]), 32'd1);
      checkEq("t2gtCnt", 32'(c8[1]), 32'd1);
      checkEq("t2ltCnt", 32'(c8[2]), 32'd2);

      // Back-to-back stream
      clrCnt = 1'b1; tick(); clrCnt = 1'b0;
      for (int i = 0; i < 6; i++) sendPair(12'(i * 37), 12'(100 - i * 20), i[0]);
      idle(3);

      // Stall with both stages full, plus blocked input attempts
      outReady = 1'b0;
      sendPair(12'h010, 12'h020, 1'b0);
      sendPair(12'h0F0, 12'h010, 1'b1);
      inValid = 1'b1; a = 12'h055; b = 12'h055;
      for (int i = 0; i < 4; i++) tick();
      checkEq("t4inReadyStall", 32'(inRdy[0]), 32'd0);
      outReady = 1'b1;
      tick();
      idle(4);

      // Saturation then clear colliding with a gt handshake
      clrCnt = 1'b1; tick(); clrCnt = 1'b0;
      for (int i = 0; i < 5; i++) sendPair(12'(i + 3), 12'(i + 3), 1'b0);
      idle(3);
      checkEq("t5eqSat", 32'(c8[0]), 32'd3);
      checkEq("t5gtZero", 32'(c8[1]), 32'd0);
      checkEq("t5ltZero", 32'(c8[2]), 32'd0);
      sendPair(12'h005, 12'h002, 1'b0);
      tick();
      clrCnt = 1'b1; tick(); clrCnt = 1'b0;
      checkEq("t5gtClrWins", 32'(c8[1]), 32'd0);
      idle(2);

      // Randomised traffic
      clrCnt = 1'b1; tick(); clrCnt = 1'b0;
      for (int i = 0; i < 800; i++) begin
         inValid  = ($urandom_range(0, 3) != 0);
         outReady = ($urandom_range(0, 2) != 0);
         a  = 12'($urandom);
         b  = ($urandom_range(0, 7) == 0) ? a : 12'($urandom);
         sm = 1'($urandom);
         tick();
      end
      inValid = 1'b0;
      outReady = 1'b1;
      idle(4);
      checkEq("drainEmpty", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_comparator.md
Name: pipe_comparator

Overview:
Parametrised, pipelined magnitude comparator. It is the successor to the fixed 4-bit combinational comparator. It accepts operand pairs over a valid/ready handshake and supports a per-transaction signed or unsigned mode. Results come out as registered one-hot flags two cycles later, with backpressure. Saturating per-outcome event counters sit alongside for datapath monitoring.

Parameters:
WIDTH, 8, operand width in bits (>=2)
CNT_W, 16, width of each event counter (>=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair A/B/signed_mode is valid
in_ready  output  1  block can accept a pair this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned
out_valid  output  1  result flags valid
out_ready  input  1  downstream accepts result
AeqB  output  1  A == B
AgtB  output  1  A > B under captured mode
AltB  output  1  A < B under captured mode
clr_cnt  input  1  synchronous clear of all counters
eq_cnt  output  CNT_W  count of delivered AeqB results
gt_cnt  output  CNT_W  count of delivered AgtB results
lt_cnt  output  CNT_W  count of delivered AltB results

Behaviour:
- Reset (rst_n low, asynchronous): both stage-valid bits = 0.
- Reset values: out_valid = 0; AeqB = AgtB = AltB = 0; all counters = 0.
- in_ready is not forced low by reset. It follows the rule below, so it reads 1 after reset.
- Reset mid-operation: in-flight pairs are discarded and nothing is delivered.
- Pipeline has two stages, each with a valid bit.
- S1 registers A, B and signed_mode on input handshake (in_valid & in_ready).
- S2 registers the comparison result of S1 contents and drives out_valid and the flags.
- Stage advance rule: a stage loads when it is empty, or when its content moves forward in the same cycle.
  - s2_adv = !s2_v | out_ready
  - s1_adv = !s1_v | s2_adv
  - in_ready = s1_adv, combinational from out_ready
  - No bubble: full throughput of 1 pair/cycle while out_ready = 1.
- Latency: input handshake in cycle N gives out_valid in cycle N+2 when there is no stall.
- Stall: while out_valid & !out_ready, the flags and out_valid hold stable. S1 holds if occupied.
- Compare rules:
  - Unsigned: plain magnitude.
  - Signed: operands interpreted as two's complement, equivalent to inverting both MSBs and then comparing unsigned.
  - Exactly one flag is high whenever out_valid = 1.
  - Flags are 0 when out_valid = 0.
- The signed_mode value travels with its own pair. Changing it between pairs never affects pairs already in flight.
- Counters:
  - On output handshake (out_valid & out_ready), the counter matching the high flag increments by 1.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt = 1 sets all counters to 0 on the next edge. Clear wins over a same-cycle increment, so the result is 0.
  - clr_cnt does not affect the pipeline.
- No combinational path from in_valid, A or B to any output.

Test Plan:
1. Reset then an idle cycle -> out_valid = 0, all flags 0, counters 0, in_ready = 1. Assert rst_n low while 2 pairs are in flight -> no result delivered after release.
2. WIDTH = 8, unsigned, A = 8'h80, B = 8'h7F -> AgtB = 1 two cycles after handshake; the same pair with signed_mode = 1 -> AltB = 1. A = B = 8'hA5 -> AeqB = 1. Signed A = 8'hFF, B = 8'h01 -> AltB.
3. Back-to-back stream of 6 pairs with out_ready = 1 -> one result per cycle, in order, with in_ready constantly 1.
4. Hold out_ready = 0 for 4 cycles with both stages full:
   - in_ready = 0 and out_valid/flags stable.
   - On release, both pairs drain in order with no loss or duplication.
   - Counters increment only on handshake cycles.
5. CNT_W = 2, 5 equal pairs delivered -> eq_cnt sticks at 3 while gt_cnt and lt_cnt stay 0. Then assert clr_cnt in the same cycle as a gt handshake -> gt_cnt = 0 next cycle.
6. Randomised A/B/signed_mode with WIDTH = 4 and 12, with random out_ready -> flags match the reference-model signed/unsigned compare. Each counter equals the number of delivered outcomes of its type.
